int_req_ctrl: RTL and testbench

Interrupt request controller: the requesting end of the processor's interrupt handshake. It latches rising edges on external interrupt sources and masks and prioritises them. It then issues a single-cycle `interrupt` pulse with the matching handler `vector` to the pipeline's interrupt state machine, and blocks further requests until the handler signals return (`rfi`). It sits between the peripheral interrupt lines / control registers and the core's interrupt sequencing logic.

---
 rtl/int_req_ctrl.sv | 159 +++++++++++++++
 tb/tb_int_req_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_req_ctrl.sv
// int_req_ctrl: latches, masks and prioritises interrupt sources
// and issues one request pulse per handler until return-from-interrupt.
module int_req_ctrl #(
  parameter int                NUM_SRC    = 8,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [ADDR_W-1:0] VEC_STRIDE = 32'h0000_0020,
  parameter int                HOLDOFF    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               msr_ee,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               clr_we,
  input  logic [NUM_SRC-1:0] clr_wdata,
  input  logic               rfi,
  output logic               interrupt,
  output logic [ADDR_W-1:0]  vector,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic               in_service,
  output logic [4:0]         svc_idx
);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    ISSUE   = 4'b0010,
    HOLD    = 4'b0100,
    SERVICE = 4'b1000
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] edge_v;
  logic [NUM_SRC-1:0] clr_v;
  logic [NUM_SRC-1:0] issue_v;
  logic [NUM_SRC-1:0] elig;
  logic               req;
  logic [4:0]         idx;
  logic [7:0]         cnt;
  logic [7:0]         cnt_nx;
  logic               rfi_lat;
  logic               rfi_lat_nx;
  logic               issue_clr;
  logic               load;

  assign edge_v = src & ~src_q;
  assign clr_v  = clr_we ? clr_wdata : '0;
  assign elig   = pending & ~mask;
  assign req    = (elig != '0) && msr_ee;

  always_comb begin
    issue_v = '0;
    if (issue_clr) issue_v = NUM_SRC'(1) << svc_idx;
  end

  // lowest eligible index wins
  always_comb begin
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) idx = 5'(i);
    end
  end

  // registered copy of the lines for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) src_q <= '0;
    else       src_q <= src;
  end

  // new edges win over software and issue clears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= edge_v | (pending & ~clr_v & ~issue_v);
  end

  // mask register, all sources masked out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        mask <= '1;
    else if (mask_we) mask <= mask_wdata;
  end

  // state, holdoff counter and early-return latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rfi_lat <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rfi_lat <= rfi_lat_nx;
    end
  end

  // capture the winning source and its handler address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      svc_idx <= '0;
      vector  <= '0;
    end else if (load) begin
      svc_idx <= idx;
      vector  <= VEC_BASE + ADDR_W'(idx) * VEC_STRIDE;
    end
  end

  // next-state and output decode
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    rfi_lat_nx = rfi_lat;
    interrupt  = 1'b0;
    in_service = 1'b0;
    issue_clr  = 1'b0;
    load       = 1'b0;
    unique case (1'b1)
      state[0]: begin
        rfi_lat_nx = 1'b0;
        if (req) begin
          load     = 1'b1;
          state_nx = ISSUE;
        end
      end
      state[1]: begin
        interrupt  = 1'b1;
        in_service = 1'b1;
        issue_clr  = 1'b1;
        cnt_nx     = 8'(HOLDOFF - 1);
        state_nx   = HOLD;
      end
      state[2]: begin
        in_service = 1'b1;
        if (rfi) rfi_lat_nx = 1'b1;
        if (cnt != '0) cnt_nx = cnt - 8'd1;
        if (cnt <= 8'd1) state_nx = SERVICE;
      end
      state[3]: begin
        in_service = 1'b1;
        if (rfi || rfi_lat) begin
          rfi_lat_nx = 1'b0;
          state_nx   = IDLE;
        end
      end
      default: begin
        state_nx   = state_t'(4'bxxxx);
        cnt_nx     = 'x;
        rfi_lat_nx = 1'bx;
        interrupt  = 1'bx;
        in_service = 1'bx;
        issue_clr  = 1'bx;
        load       = 1'bx;
      end
    endcase
  end

endmodule

// File: tb/tb_int_req_ctrl.sv
// tb_int_req_ctrl: directed checks of the interrupt request controller
// covering issue, priority, masking, gating, early return and reset.
module tb_int_req_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  src;
  logic        msr_ee;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        clr_we;
  logic [7:0]  clr_wdata;
  logic        rfi;
  logic        interrupt;
  logic [31:0] vector;
  logic [7:0]  pending;
  logic [7:0]  mask;
  logic        in_service;
  logic [4:0]  svc_idx;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int base_pulses;

  int_req_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .src        (src),
    .msr_ee     (msr_ee),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .clr_we     (clr_we),
    .clr_wdata  (clr_wdata),
    .rfi        (rfi),
    .interrupt  (interrupt),
    .vector     (vector),
    .pending    (pending),
    .mask       (mask),
    .in_service (in_service),
    .svc_idx    (svc_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (interrupt === 1'b1) pulses++;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    src        = '0;
    msr_ee     = 1'b0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    clr_we     = 1'b0;
    clr_wdata  = '0;
    rfi        = 1'b0;
    cyc();
    cyc();
    chk("rst_int", 32'(interrupt), 32'h0);
    chk("rst_pend", 32'(pending), 32'h0);
    chk("rst_mask", 32'(mask), 32'hFF);
    chk("rst_insvc", 32'(in_service), 32'h0);
    chk("rst_idx", 32'(svc_idx), 32'h0);
    chk("rst_vec", vector, 32'h0);
    reset = 1'b0;
    cyc();
    mask_we    = 1'b1;
    mask_wdata = 8'h00;
    msr_ee     = 1'b1;
    cyc();
    mask_we = 1'b0;
    chk("mask_wr", 32'(mask), 32'h00);

    // basic issue: edge on src[3] at t
    src = 8'h08;
    chk("b_t0_int", 32'(interrupt), 32'h0);
    cyc();
    chk("b_t1_pend", 32'(pending), 32'h08);
    chk("b_t1_int", 32'(interrupt), 32'h0);
    cyc();
    chk("b_t2_int", 32'(interrupt), 32'h1);
    chk("b_t2_vec", vector, 32'h160);
    chk("b_t2_idx", 32'(svc_idx), 32'h3);
    chk("b_t2_insvc", 32'(in_service), 32'h1);
    cyc();
    chk("b_t3_int", 32'(interrupt), 32'h0);
    chk("b_t3_pend", 32'(pending), 32'h00);
    src = 8'h00;
    cyc();
    cyc();
    chk("b_t5_insvc", 32'(in_service), 32'h1);
    cyc();
    rfi = 1'b1;
    chk("b_t6_insvc", 32'(in_service), 32'h1);
    cyc();
    rfi = 1'b0;
    chk("b_t7_insvc", 32'(in_service), 32'h0);
    cyc();

    // priority: src[5] and src[1] together
    src = 8'h22;
    cyc();
    chk("p_u1_pend", 32'(pending), 32'h22);
    cyc();
    chk("p_u2_int", 32'(interrupt), 32'h1);
    chk("p_u2_vec", vector, 32'h120);
    chk("p_u2_idx", 32'(svc_idx), 32'h1);
    cyc();
    chk("p_u3_pend", 32'(pending), 32'h20);
    chk("p_u3_int", 32'(interrupt), 32'h0);
    cyc();
    cyc();
    rfi = 1'b1;
    chk("p_u5_pend", 32'(pending), 32'h20);
    chk("p_u5_insvc", 32'(in_service), 32'h1);
    cyc();
    rfi = 1'b0;
    chk("p_u6_int", 32'(interrupt), 32'h0);
    chk("p_u6_insvc", 32'(in_service), 32'h0);
    cyc();
    chk("p_u7_int", 32'(interrupt), 32'h1);
    chk("p_u7_vec", vector, 32'h1A0);
    chk("p_u7_idx", 32'(svc_idx), 32'h5);
    cyc();
    cyc();
    cyc();
    rfi = 1'b1;
    src = 8'h00;
    cyc();
    rfi = 1'b0;
    chk("p_ret_insvc", 32'(in_service), 32'h0);

    // masking
    mask_we    = 1'b1;
    mask_wdata = 8'hFF;
    cyc();
    mask_we = 1'b0;
    src     = 8'h01;
    cyc();
    chk("m_pend", 32'(pending), 32'h01);
    cyc();
    chk("m_int0", 32'(interrupt), 32'h0);
    chk("m_pend2", 32'(pending), 32'h01);
    cyc();
    chk("m_int1", 32'(interrupt), 32'h0);
    chk("m_insvc", 32'(in_service), 32'h0);
    mask_we    = 1'b1;
    mask_wdata = 8'h00;
    cyc();
    mask_we = 1'b0;
    chk("m_w1_int", 32'(interrupt), 32'h0);
    cyc();
    chk("m_w2_int", 32'(interrupt), 32'h1);
    chk("m_w2_vec", vector, 32'h100);

    // early return during HOLD
    cyc();
    rfi = 1'b1;
    src = 8'h00;
    chk("e_h1_insvc", 32'(in_service), 32'h1);
    cyc();
    rfi = 1'b0;
    chk("e_h2_insvc", 32'(in_service), 32'h1);
    cyc();
    chk("e_svc_insvc", 32'(in_service), 32'h1);
    cyc();
    chk("e_idle_insvc", 32'(in_service), 32'h0);
    chk("e_idle_int", 32'(interrupt), 32'h0);

    // gating with msr_ee and software clear
    msr_ee = 1'b0;
    src    = 8'h04;
    cyc();
    chk("g_pend", 32'(pending), 32'h04);
    rfi = 1'b1;
    cyc();
    rfi = 1'b0;
    chk("g_int0", 32'(interrupt), 32'h0);
    cyc();
    chk("g_int1", 32'(interrupt), 32'h0);
    chk("g_insvc", 32'(in_service), 32'h0);
    clr_we    = 1'b1;
    clr_wdata = 8'h04;
    cyc();
    clr_we = 1'b0;
    chk("g_clr", 32'(pending), 32'h00);
    src = 8'h00;
    cyc();
    src    = 8'h04;
    clr_we = 1'b1;
    cyc();
    chk("g_set_wins", 32'(pending), 32'h04);
    msr_ee = 1'b1;
    cyc();
    clr_we = 1'b0;
    chk("g_clr_dec_int", 32'(interrupt), 32'h1);
    chk("g_clr_dec_idx", 32'(svc_idx), 32'h2);
    chk("g_clr_dec_vec", vector, 32'h140);
    cyc();
    cyc();
    cyc();
    cyc();
    chk("g_wait_insvc", 32'(in_service), 32'h1);
    cyc();
    chk("g_wait2_insvc", 32'(in_service), 32'h1);
    rfi = 1'b1;
    src = 8'h00;
    cyc();
    rfi = 1'b0;
    chk("g_ret_insvc", 32'(in_service), 32'h0);

    // reset in HOLD with two sources pending
    src = 8'h01;
    cyc();
    cyc();
    chk("r_int", 32'(interrupt), 32'h1);
    cyc();
    src = 8'h31;
    cyc();
    chk("r_hold_pend", 32'(pending), 32'h30);
    chk("r_hold_insvc", 32'(in_service), 32'h1);
    src = 8'h00;
    #1;
    reset = 1'b1;
    #1;
    chk("r_async_int", 32'(interrupt), 32'h0);
    chk("r_async_pend", 32'(pending), 32'h00);
    chk("r_async_mask", 32'(mask), 32'hFF);
    chk("r_async_insvc", 32'(in_service), 32'h0);
    cyc();
    base_pulses = pulses;
    cyc();
    reset = 1'b0;
    repeat (6) cyc();
    chk("r_no_pulse", 32'(pulses - base_pulses), 32'h0);
    chk("total_pulses", 32'(pulses), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
